// File: rtl/unidad_control.sv
// rtl/unidad_control.sv - shift-add multiplier control unit (Moore FSM + iteration counter)
module unidad_control #(
    parameter int N_BITS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic q0,
    output logic carga_ini,
    output logic clr_a,
    output logic carga,
    output logic desplaza,
    output logic ocupado,
    output logic fin
);

    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [CW-1:0] C_ULTIMO = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        INICIO   = 3'd1,
        TEST     = 3'd2,
        SUMA     = 3'd3,
        DESPLAZA = 3'd4,
        FIN      = 3'd5
    } estado_t;

    estado_t         r_estado;
    logic [CW-1:0]   r_cnt;

    // State sequencing and iteration count; the last shift exits to FIN so cnt never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= REPOSO;
            r_cnt    <= '0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (inicio) r_estado <= INICIO;
                end
                INICIO: begin
                    r_cnt    <= '0;
                    r_estado <= TEST;
                end
                TEST: begin
                    r_estado <= q0 ? SUMA : DESPLAZA;
                end
                SUMA: begin
                    r_estado <= DESPLAZA;
                end
                DESPLAZA: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_estado <= (r_cnt == C_ULTIMO) ? FIN : TEST;
                end
                FIN: begin
                    // Holding inicio keeps us here so a run only restarts after inicio drops
                    if (!inicio) r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    // Moore decode: outputs depend only on the current state, so reset clears them at once
    always_comb begin
        carga_ini = (r_estado == INICIO);
        clr_a     = (r_estado == INICIO);
        carga     = (r_estado == SUMA);
        desplaza  = (r_estado == DESPLAZA);
        ocupado   = (r_estado == INICIO) || (r_estado == TEST) ||
                    (r_estado == SUMA)   || (r_estado == DESPLAZA);
        fin       = (r_estado == FIN);
    end

endmodule

// File: tb/tb_unidad_control.sv
// tb/tb_unidad_control.sv - scoreboard bench for unidad_control closed-loop with a datapath model
module tb_unidad_control;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic inicio = 1'b0;
    logic q0;
    logic carga_ini, clr_a, carga, desplaza, ocupado, fin;

    unidad_control #(.N_BITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio),
        .q0        (q0),
        .carga_ini (carga_ini),
        .clr_a     (clr_a),
        .carga     (carga),
        .desplaza  (desplaza),
        .ocupado   (ocupado),
        .fin       (fin)
    );

    always #5 clk = ~clk;

    // Behavioural camino_datos: C:A:Q shift-add datapath driven by the controller
    logic [3:0]   mc_in;
    logic [N-1:0] mp_in;
    logic [3:0]   dp_m, dp_a;
    logic         dp_c;
    logic [N-1:0] dp_q;
    assign q0 = dp_q[0];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_m <= '0; dp_a <= '0; dp_c <= 1'b0; dp_q <= '0;
        end else if (carga_ini) begin
            dp_m <= mc_in;
            dp_q <= mp_in;
            if (clr_a) begin dp_a <= '0; dp_c <= 1'b0; end
        end else if (carga) begin
            {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
        end else if (desplaza) begin
            {dp_c, dp_a, dp_q} <= {1'b0, dp_c, dp_a, dp_q[N-1:1]};
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard queues: op codes 1=carga_ini 2=carga 3=desplaza
    int q_ops[$];
    int q_lat[$];
    int q_prod[$];
    int cyc = 0;
    logic fin_prev = 1'b0;

    // Monitor: compare every datapath pulse and each completion against the queued expectations
    always @(negedge clk) begin
        int code;
        int e;
        if (!reset) begin
            cyc = 0;
            fin_prev = 1'b0;
        end else begin
            if (carga_ini) cyc = 1;
            else if (cyc > 0) cyc++;
            if (carga_ini || carga || desplaza || clr_a) begin
                code = carga_ini ? 1 : (carga ? 2 : 3);
                check("op_onehot", int'(carga_ini) + int'(carga) + int'(desplaza), 1);
                check("clr_a_with_carga_ini", clr_a, carga_ini);
                check("op_ocupado", ocupado, 1);
                if (q_ops.size() == 0) check("unexpected_op", code, 0);
                else begin
                    e = q_ops.pop_front();
                    check("op_order", code, e);
                end
            end
            if (fin && !fin_prev) begin
                check("fin_ocupado", ocupado, 0);
                if (q_lat.size() == 0) check("unexpected_fin", 1, 0);
                else begin
                    e = q_lat.pop_front();
                    check("latency", cyc, e);
                    e = q_prod.pop_front();
                    check("product", {25'd0, dp_a, dp_q}, e);
                    check("ops_drained", q_ops.size(), 0);
                end
                cyc = 0;
            end
            fin_prev = fin;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_run(input logic [3:0] mc, input logic [N-1:0] mp);
        mc_in = mc;
        mp_in = mp;
        q_ops.push_back(1);
        for (int i = 0; i < N; i++) begin
            if (mp[i]) q_ops.push_back(2);
            q_ops.push_back(3);
        end
        q_lat.push_back(2 + 2 * N + $countones(mp));
        q_prod.push_back(int'(mc) * int'(mp));
    endtask

    task automatic run(input logic [3:0] mc, input logic [N-1:0] mp, input bit poke, input bit hold);
        bit done;
        push_run(mc, mp);
        inicio = 1'b1;
        step();
        if (!hold) inicio = 1'b0;
        if (poke) begin
            step(); step();
            inicio = 1'b1; step();
            inicio = 1'b0; step();
            inicio = 1'b1; step();
            inicio = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (fin) begin done = 1'b1; break; end
            step();
        end
        check("fin_timeout", done, 1);
    endtask

    initial begin
        bit got;
        mc_in = '0;
        mp_in = '0;
        #2;
        check("rst_carga_ini", carga_ini, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_fin", fin, 0);
        step(); step();
        reset = 1'b1;
        step();
        check("idle_after_rst", {ocupado, fin, carga_ini}, 0);

        // multiplier 0 -> carga_ini, 3 shifts, fin at cycle 8
        run(4'd9, 3'd0, 0, 0);
        step();
        check("idle_ocupado", ocupado, 0);
        check("idle_fin", fin, 0);

        // multiplier 7 -> carga before each shift, fin at cycle 11
        run(4'd15, 3'd7, 0, 0);
        step();
        check("idle_fin", fin, 0);

        // closed loop 5 x 3 = 15
        run(4'd5, 3'd3, 0, 0);
        step();

        // inicio toggling while busy is ignored; same result as multiplier 0
        run(4'd6, 3'd0, 1, 0);
        step();
        check("idle_after_poke", {ocupado, fin}, 0);

        // inicio held through completion: stays in FIN, no restart
        run(4'd5, 3'd3, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("hold_fin", fin, 1);
            check("hold_no_restart", carga_ini, 0);
        end
        inicio = 1'b0;
        step();
        check("fin_released", fin, 0);
        run(4'd11, 3'd5, 0, 0);
        step();

        // a few random operands
        for (int i = 0; i < 4; i++) begin
            run(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 0, 0);
            step();
        end

        // asynchronous reset during SUMA aborts the run immediately
        push_run(4'd5, 3'd3);
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (carga) begin got = 1'b1; break; end
            step();
        end
        check("reached_suma", got, 1);
        reset = 1'b0;
        #1;
        check("abort_outputs", {carga_ini, clr_a, carga, desplaza, ocupado, fin}, 0);
        q_ops.delete();
        q_lat.delete();
        q_prod.delete();
        cyc = 0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_abort_idle", {ocupado, fin}, 0);
        end
        run(4'd7, 3'd6, 0, 0);
        step();

        check("queues_empty", q_ops.size() + q_lat.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
